// File: rtl/axis_packetizer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : axis_packetizer_pkg
// Brief   : Shared state encoding and default widths for the AXIS packetizer.
// Revision: 1.0
// ----------------------------------------------------------------------------
package axis_packetizer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axis_packetizer_skid_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : axis_skid_buffer
// Brief   : Two-entry registered skid buffer; in_ready depends only on state.
// Revision: 1.0
// ----------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             w_load;
  logic             w_push;

  assign w_load = out_ready || !out_valid_q;
  assign w_push = in_valid && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (w_load) begin
      // Skid entry always drains first; input is blocked while it is occupied.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (w_push) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign empty     = !out_valid_q && !skid_valid_q;

endmodule
`default_nettype wire

// File: rtl/axis_packetizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : axis_packetizer
// Brief   : Cuts a continuous AXI4-Stream into armed fixed-length TLAST packets.
// Revision: 1.0
// ----------------------------------------------------------------------------
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  dropped
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0] dropped_q, dropped_d;

  logic                  w_last;
  logic                  w_in_valid;
  logic                  w_in_ready;
  logic                  w_empty;
  logic [DATA_WIDTH:0]   w_out_data;

  // len_q is never zero outside IDLE, so len_q-1 cannot wrap while in use.
  assign w_last     = (beat_cnt_q == (len_q - LEN_WIDTH'(1)));
  assign w_in_valid = (state_q == ST_RUN) && s_tvalid;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    dropped_d  = dropped_q;
    s_tready   = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_tready = 1'b1;
        if (s_tvalid && (dropped_q != {LEN_WIDTH{1'b1}})) begin
          dropped_d = dropped_q + LEN_WIDTH'(1);
        end
        if (start && (frame_len != '0)) begin
          state_d    = ST_RUN;
          len_d      = frame_len;
          beat_cnt_d = '0;
          dropped_d  = '0;
        end
      end
      ST_RUN: begin
        s_tready = w_in_ready;
        if (s_tvalid && w_in_ready) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (w_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      dropped_q  <= dropped_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .in_data  ({w_last, s_tdata}),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data (w_out_data),
    .empty    (w_empty)
  );

  assign m_tlast = w_out_data[DATA_WIDTH];
  assign m_tdata = w_out_data[DATA_WIDTH-1:0];
  assign busy    = (state_q != ST_IDLE);
  assign dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_packetizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_axis_packetizer
// Brief   : Self-checking bench: packet table, cycle model and output scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_axis_packetizer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic        busy;
  logic        done;
  logic [15:0] dropped;

  int errors = 0;
  int checks = 0;

  axis_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle model of the packetizer plus the expected contents of the skid buffer.
  logic [32:0] exp_q[$];
  int          mstate = M_IDLE;
  int          mlen = 0;
  int          mcnt = 0;
  logic [15:0] mdropped = '0;
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  logic [32:0] word;
  logic        rdy;
  logic        lastb;
  logic        in_pkt = 1'b0;
  int          n;
  int          cyc = 0;
  int          last_out_cyc = 0;
  int          beats_out = 0;
  int          dones = 0;
  int          gaps = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      n   = exp_q.size();
      rdy = (mstate == M_IDLE) || (mstate == M_RUN && n < 2);
      chk("s_tready", s_tready, rdy);
      chk("m_tvalid", m_tvalid, n != 0);
      chk("busy", busy, mstate != M_IDLE);
      chk("done", done, mstate == M_DRAIN && n == 0);
      chk("dropped", dropped, mdropped);
      if (prev_stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_word});
      if (done) dones++;
      if (m_tvalid && m_tready && n != 0) begin
        word = exp_q.pop_front();
        chk("m_tdata", m_tdata, word[31:0]);
        chk("m_tlast", m_tlast, word[32]);
        beats_out++;
        if (in_pkt && cyc != last_out_cyc + 1) gaps++;
        in_pkt       = !word[32];
        last_out_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
      if (reset) begin
        mstate     = M_IDLE;
        mdropped   = '0;
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
        exp_q.delete();
      end else begin
        case (mstate)
          M_IDLE: begin
            if (s_tvalid && mdropped != 16'hFFFF) mdropped++;
            if (start && frame_len != 0) begin
              mstate   = M_RUN;
              mlen     = int'(frame_len);
              mcnt     = 0;
              mdropped = '0;
            end
          end
          M_RUN: begin
            if (s_tvalid && rdy) begin
              lastb = (mcnt == mlen - 1);
              exp_q.push_back({lastb, s_tdata});
              mcnt++;
              if (lastb) mstate = M_DRAIN;
            end
          end
          default: if (n == 0) mstate = M_IDLE;
        endcase
      end
    end
  end

  function automatic logic mready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  typedef struct {
    int len;
    int mode;        // 0: m_tready high, 1: toggling, 2: random
    bit tv_on_start; // junk beat alongside the start pulse
    bit second;      // extra start (frame_len=3) while busy
    bit check_gap;
    int exp_beats;
    int exp_dones;
  } vec_t;

  task automatic run_packet(input vec_t v, input int base, input int idx);
    int  d;
    int  b0, d0, g0, after;
    bit  seen;
    d  = base + 1;
    b0 = beats_out; d0 = dones; g0 = gaps;
    seen = 0; after = 0;
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'(v.len);
    s_tvalid = v.tv_on_start; s_tdata = 32'hDEAD0000 + 32'(idx);
    m_tready = mready(v.mode, 0);
    for (int c = 0; c < 400 && after < 3; c++) begin
      @(posedge clk); #1;
      start     = v.second && (c == 0);
      frame_len = (v.second && c == 0) ? 16'd3 : 16'd0;
      s_tvalid  = 1'b1;
      s_tdata   = 32'(d);
      m_tready  = mready(v.mode, c + 1);
      @(negedge clk);
      #1;
      if (s_tvalid && s_tready) d++;
      if (dones != d0) seen = 1;
      if (seen) after++;
    end
    @(posedge clk); #1;
    start = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    chk($sformatf("row%0d_beats", idx), 64'(beats_out - b0), 64'(v.exp_beats));
    chk($sformatf("row%0d_dones", idx), 64'(dones - d0), 64'(v.exp_dones));
    if (v.check_gap) chk($sformatf("row%0d_gaps", idx), 64'(gaps - g0), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int acc, d0;
    vecs[0] = '{4,  0, 0, 0, 1, 4,  1};
    vecs[1] = '{8,  1, 0, 0, 0, 8,  1};
    vecs[2] = '{1,  0, 0, 1, 1, 1,  1};
    vecs[3] = '{3,  2, 1, 0, 0, 3,  1};
    vecs[4] = '{16, 2, 0, 1, 0, 16, 1};
    vecs[5] = '{2,  0, 1, 0, 1, 2,  1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dropped", dropped, 16'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle beats are dropped and counted
    s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 32'(i);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("idle_dropped", dropped, 16'd10);

    for (int i = 0; i < 6; i++) run_packet(vecs[i], 100 * (i + 1), i);

    // Reset after 2 of 5 beats, with the downstream stalled
    d0 = dones; acc = 0;
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd5; m_tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h900;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk); #1;
      if (s_tready) acc++;
      @(posedge clk); #1;
      s_tdata = 32'h900 + 32'(acc);
    end
    chk("mid_accepted", 64'(acc), 64'd2);
    s_tvalid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    chk("mid_m_tvalid", m_tvalid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    repeat (6) @(posedge clk);
    chk("mid_no_done", 64'(dones - d0), 64'd0);
    run_packet('{2, 0, 0, 0, 1, 2, 1}, 2000, 6);

    // frame_len=0 is ignored; drop counter saturates
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd0; s_tvalid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_busy", busy, 1'b0);
    repeat (70000) @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk);
    chk("sat_dropped", dropped, 16'hFFFF);
    chk("sat_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
